// File: rtl/id_ex_stage_pkg.sv
// Shared widths, operand-category codes and ALU opcode constants for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int OPC_W   = 5;

    // Operand-B category codes; only CAT_REG marks B as a register read.
    localparam logic [1:0] CAT_REG   = 2'b00;
    localparam logic [1:0] CAT_IMM   = 2'b01;
    localparam logic [1:0] CAT_UPPER = 2'b10;
    localparam logic [1:0] CAT_PC    = 2'b11;

    // ALU operations carried through to EX.
    localparam logic [OPC_W-1:0] OPC_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OPC_AND = 5'd2;
    localparam logic [OPC_W-1:0] OPC_OR  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_XOR = 5'd4;
    localparam logic [OPC_W-1:0] OPC_SLL = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SRL = 5'd6;
    localparam logic [OPC_W-1:0] OPC_LD  = 5'd7;
    localparam logic [OPC_W-1:0] OPC_ST  = 5'd8;

    // True when the category says operand B came from the register file.
    function automatic logic is_reg_operand(input logic [1:0] category);
        return (category == CAT_REG);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// One forwarding selector: EX/MEM result beats MEM/WB result beats the captured value.
module id_ex_stage_forward_mux #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]  reg_val,
    input  logic               enable,
    input  logic               exmem_write_back,
    input  logic [RADDR_W-1:0] exmem_dst_addr,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_write_back,
    input  logic [RADDR_W-1:0] memwb_dst_addr,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  fwd_val
);

    // Pick the youngest in-flight producer of addr; register 0 is not special.
    always_comb begin
        fwd_val = reg_val;
        if (enable && exmem_write_back && (exmem_dst_addr == addr)) begin
            fwd_val = exmem_result;
        end else if (enable && memwb_write_back && (memwb_dst_addr == addr)) begin
            fwd_val = memwb_result;
        end else begin
            fwd_val = reg_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = id_ex_stage_pkg::DATA_W,
    parameter int RADDR_W = id_ex_stage_pkg::RADDR_W,
    parameter int OPC_W   = id_ex_stage_pkg::OPC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_read_data1,
    input  logic [DATA_W-1:0]  in_alu_input2,
    input  logic [RADDR_W-1:0] in_src_addr,
    input  logic [RADDR_W-1:0] in_dst_addr,
    input  logic [1:0]         in_category,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic               in_write_back,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               exmem_write_back,
    input  logic [RADDR_W-1:0] exmem_dst_addr,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_write_back,
    input  logic [RADDR_W-1:0] memwb_dst_addr,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic               load_use_hazard,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_operand_a,
    output logic [DATA_W-1:0]  ex_operand_b,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [RADDR_W-1:0] ex_dst_addr,
    output logic [OPC_W-1:0]   ex_opcode,
    output logic               ex_write_back,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);

    logic               valid_q,    valid_d;
    logic [DATA_W-1:0]  a_q,        a_d;
    logic [DATA_W-1:0]  b_q,        b_d;
    logic [RADDR_W-1:0] src_q,      src_d;
    logic [RADDR_W-1:0] dst_q,      dst_d;
    logic [OPC_W-1:0]   opc_q,      opc_d;
    logic               b_is_reg_q, b_is_reg_d;
    logic               wb_q,       wb_d;
    logic               mr_q,       mr_d;
    logic               mw_q,       mw_d;
    logic               hazard_s;

    // A load in EX whose destination is read by the instruction in ID must wait one cycle.
    always_comb begin
        hazard_s = in_valid && valid_q && mr_q && wb_q &&
                   ((dst_q == in_src_addr) ||
                    (is_reg_operand(in_category) && (dst_q == in_dst_addr)));
    end

    // Next-state selection: flush, then stall, then bubble, then normal capture.
    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        src_d      = src_q;
        dst_d      = dst_q;
        opc_d      = opc_q;
        b_is_reg_d = b_is_reg_q;
        wb_d       = wb_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        if (flush || (!stall && hazard_s)) begin
            // Squash or bubble: zero controls so nothing can write or touch memory.
            valid_d = 1'b0;
            wb_d    = 1'b0;
            mr_d    = 1'b0;
            mw_d    = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d    = in_valid;
            a_d        = in_read_data1;
            b_d        = in_alu_input2;
            src_d      = in_src_addr;
            dst_d      = in_dst_addr;
            opc_d      = in_opcode;
            b_is_reg_d = is_reg_operand(in_category);
            wb_d       = in_write_back && in_valid;
            mr_d       = in_mem_read   && in_valid;
            mw_d       = in_mem_write  && in_valid;
        end
    end

    // Pipeline register; asynchronous clear leaves every field at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            opc_q      <= '0;
            b_is_reg_q <= 1'b0;
            wb_q       <= 1'b0;
            mr_q       <= 1'b0;
            mw_q       <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            opc_q      <= opc_d;
            b_is_reg_q <= b_is_reg_d;
            wb_q       <= wb_d;
            mr_q       <= mr_d;
            mw_q       <= mw_d;
        end
    end

    id_ex_stage_forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
        .addr(src_q), .reg_val(a_q), .enable(1'b1),
        .exmem_write_back(exmem_write_back), .exmem_dst_addr(exmem_dst_addr), .exmem_result(exmem_result),
        .memwb_write_back(memwb_write_back), .memwb_dst_addr(memwb_dst_addr), .memwb_result(memwb_result),
        .fwd_val(ex_operand_a)
    );

    // Immediates are never overridden: B forwards only when it was a register read.
    id_ex_stage_forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
        .addr(dst_q), .reg_val(b_q), .enable(b_is_reg_q),
        .exmem_write_back(exmem_write_back), .exmem_dst_addr(exmem_dst_addr), .exmem_result(exmem_result),
        .memwb_write_back(memwb_write_back), .memwb_dst_addr(memwb_dst_addr), .memwb_result(memwb_result),
        .fwd_val(ex_operand_b)
    );

    // Store data is the register named by dst, whatever the operand-B category was.
    id_ex_stage_forward_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_st (
        .addr(dst_q), .reg_val(b_q), .enable(1'b1),
        .exmem_write_back(exmem_write_back), .exmem_dst_addr(exmem_dst_addr), .exmem_result(exmem_result),
        .memwb_write_back(memwb_write_back), .memwb_dst_addr(memwb_dst_addr), .memwb_result(memwb_result),
        .fwd_val(ex_store_data)
    );

    assign load_use_hazard = hazard_s;
    assign ex_valid        = valid_q;
    assign ex_dst_addr     = dst_q;
    assign ex_opcode       = opc_q;
    assign ex_write_back   = wb_q;
    assign ex_mem_read     = mr_q;
    assign ex_mem_write    = mw_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a per-cycle reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid;
    logic [15:0] in_read_data1, in_alu_input2;
    logic [2:0]  in_src_addr, in_dst_addr;
    logic [1:0]  in_category;
    logic [4:0]  in_opcode;
    logic        in_write_back, in_mem_read, in_mem_write;
    logic        exmem_write_back, memwb_write_back;
    logic [2:0]  exmem_dst_addr, memwb_dst_addr;
    logic [15:0] exmem_result, memwb_result;
    logic        load_use_hazard, ex_valid, ex_write_back, ex_mem_read, ex_mem_write;
    logic [15:0] ex_operand_a, ex_operand_b, ex_store_data;
    logic [2:0]  ex_dst_addr;
    logic [4:0]  ex_opcode;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_read_data1(in_read_data1), .in_alu_input2(in_alu_input2),
        .in_src_addr(in_src_addr), .in_dst_addr(in_dst_addr), .in_category(in_category),
        .in_opcode(in_opcode), .in_write_back(in_write_back), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write),
        .exmem_write_back(exmem_write_back), .exmem_dst_addr(exmem_dst_addr), .exmem_result(exmem_result),
        .memwb_write_back(memwb_write_back), .memwb_dst_addr(memwb_dst_addr), .memwb_result(memwb_result),
        .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .ex_operand_a(ex_operand_a),
        .ex_operand_b(ex_operand_b), .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr),
        .ex_opcode(ex_opcode), .ex_write_back(ex_write_back), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    always #5 clk = ~clk;

    // Reference view of what the EX stage holds.
    typedef struct packed {
        logic        valid;
        logic [15:0] a, b;
        logic [2:0]  src, dst;
        logic [4:0]  opc;
        logic        breg, wb, mr, mw;
    } ex_t;
    ex_t m;

    function automatic logic [15:0] fwd(input logic [2:0] addr, input logic [15:0] held);
        if (exmem_write_back && exmem_dst_addr == addr) return exmem_result;
        if (memwb_write_back && memwb_dst_addr == addr) return memwb_result;
        return held;
    endfunction

    function automatic logic exp_hazard();
        return in_valid && m.valid && m.mr && m.wb &&
               (m.dst == in_src_addr || (in_category == 2'b00 && m.dst == in_dst_addr));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model update: what each clock edge must do to the EX contents.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (flush || (!stall && exp_hazard())) begin
            m.valid <= 1'b0; m.wb <= 1'b0; m.mr <= 1'b0; m.mw <= 1'b0;
        end else if (!stall) begin
            m <= '{valid: in_valid, a: in_read_data1, b: in_alu_input2, src: in_src_addr,
                   dst: in_dst_addr, opc: in_opcode, breg: (in_category == 2'b00),
                   wb: in_write_back & in_valid, mr: in_mem_read & in_valid,
                   mw: in_mem_write & in_valid};
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("m_hazard", {31'd0, load_use_hazard}, {31'd0, exp_hazard()});
            chk("m_valid",  {31'd0, ex_valid},        {31'd0, m.valid});
            chk("m_ctrl",   {29'd0, ex_write_back, ex_mem_read, ex_mem_write},
                            {29'd0, m.wb, m.mr, m.mw});
            if (m.valid) begin
                chk("m_op_a",  {16'd0, ex_operand_a},  {16'd0, fwd(m.src, m.a)});
                chk("m_op_b",  {16'd0, ex_operand_b},  {16'd0, m.breg ? fwd(m.dst, m.b) : m.b});
                chk("m_store", {16'd0, ex_store_data}, {16'd0, fwd(m.dst, m.b)});
                chk("m_dst_opc", {24'd0, ex_dst_addr, ex_opcode}, {24'd0, m.dst, m.opc});
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] src, input logic [2:0] dst, input logic [1:0] cat,
                         input logic [4:0] opc, input logic wb, input logic mr, input logic mw);
        in_valid = v; in_read_data1 = a; in_alu_input2 = b; in_src_addr = src;
        in_dst_addr = dst; in_category = cat; in_opcode = opc;
        in_write_back = wb; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic fwd_set(input logic ew, input logic [2:0] ed, input logic [15:0] er,
                           input logic mwb, input logic [2:0] md, input logic [15:0] mres);
        exmem_write_back = ew; exmem_dst_addr = ed; exmem_result = er;
        memwb_write_back = mwb; memwb_dst_addr = md; memwb_result = mres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        fwd_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        #12 rst_n = 1'b1;
        #1;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_op_a", {16'd0, ex_operand_a}, 32'h0);

        // Pass-through with register operand B.
        drive(1'b1, 16'h1234, 16'h0005, 3'd1, 3'd2, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        chk("pass_a", {16'd0, ex_operand_a}, 32'h1234);
        chk("pass_b", {16'd0, ex_operand_b}, 32'h0005);
        chk("pass_valid", {31'd0, ex_valid}, 32'd1);

        // Forwarding priority on A.
        drive(1'b1, 16'h1111, 16'h2222, 3'd3, 3'd5, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
        fwd_set(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3, 16'h5555);
        #1;
        chk("fwd_exmem_a", {16'd0, ex_operand_a}, 32'hAAAA);
        chk("fwd_b_nomatch", {16'd0, ex_operand_b}, 32'h2222);
        exmem_write_back = 1'b0;
        #1;
        chk("fwd_memwb_a", {16'd0, ex_operand_a}, 32'h5555);
        fwd_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        // Immediate operand B is never overridden; store data is.
        drive(1'b1, 16'h0, 16'h00FF, 3'd6, 3'd2, 2'b01, 5'd8, 1'b0, 1'b0, 1'b1);
        step();
        fwd_set(1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 16'h0);
        #1;
        chk("imm_b", {16'd0, ex_operand_b}, 32'h00FF);
        chk("imm_store", {16'd0, ex_store_data}, 32'hBEEF);
        fwd_set(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

        // Load-use on operand A.
        drive(1'b1, 16'h0, 16'h0010, 3'd0, 3'd4, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h4444, 16'h0001, 3'd4, 3'd1, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_wb", {31'd0, ex_write_back}, 32'd0);
        chk("lu_hazard_drop", {31'd0, load_use_hazard}, 32'd0);
        step();
        chk("lu_enter_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_enter_a", {16'd0, ex_operand_a}, 32'h4444);

        // Load-use through operand B depends on the category.
        drive(1'b1, 16'h0, 16'h0, 3'd7, 3'd4, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h0, 3'd1, 3'd4, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_b_imm", {31'd0, load_use_hazard}, 32'd0);
        in_category = 2'b00;
        #1;
        chk("lu_b_reg", {31'd0, load_use_hazard}, 32'd1);
        in_valid = 1'b0;
        #1;
        chk("lu_invalid", {31'd0, load_use_hazard}, 32'd0);
        step();

        // Flush wins over stall and hazard.
        drive(1'b1, 16'h7777, 16'h0, 3'd0, 3'd3, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0, 16'h0, 3'd3, 3'd1, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; flush = 1'b1;
        #1;
        chk("flush_hz_on", {31'd0, load_use_hazard}, 32'd1);
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_mr", {31'd0, ex_mem_read}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Stall holds everything for three cycles.
        drive(1'b1, 16'h6666, 16'h0, 3'd0, 3'd5, 2'b01, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        stall = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 3'd1, 3'd1, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_a", {16'd0, ex_operand_a}, 32'h6666);
            chk("stall_opc", {27'd0, ex_opcode}, 32'd9);
        end
        stall = 1'b0;
        step();
        chk("unstall_valid", {31'd0, ex_valid}, 32'd0);

        // Asynchronous reset mid-run.
        drive(1'b1, 16'h0ABC, 16'h0DEF, 3'd1, 3'd2, 2'b00, 5'd4, 1'b1, 1'b0, 1'b1);
        step();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_data", {ex_operand_a, ex_operand_b}, 32'h0);
        chk("arst_store", {16'd0, ex_store_data}, 32'h0);
        chk("arst_ctrl", {21'd0, ex_dst_addr, ex_opcode, ex_write_back, ex_mem_read, ex_mem_write}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Mixed traffic checked by the model every cycle.
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom));
            fwd_set(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
        end
        step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
